inst_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the processor's execute/register-file unit. It maintains the program counter, reads 32-bit instruction words from program memory over a req/ack handshake, and presents each word to the execute stage in the IR format: oper_type [31:27], rdst [26:22], rsrc1 [21:17], imm_mode [16], rsrc2 [15:11], isrc [15:0]. Execute returns jump redirects and halt requests.

---
 rtl/inst_fetch_if.sv | 27 ++
 rtl/inst_fetch.sv | 110 +++++++++++
 tb/tb_inst_fetch.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Instruction-fetch bus bundle: the program-memory read port and the IR port toward execute.
// The master modport is the fetch side; the slave modport is the memory/execute side.
interface inst_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int INST_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;
    logic [INST_W-1:0] ir;
    logic              ir_valid;
    logic              ir_ready;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic [ADDR_W-1:0] pc;

    modport master (
        output imem_req, imem_addr, ir, ir_valid, pc,
        input  imem_ack, imem_rdata, ir_ready, jump_en, jump_addr
    );

    modport slave (
        input  imem_req, imem_addr, ir, ir_valid, pc,
        output imem_ack, imem_rdata, ir_ready, jump_en, jump_addr
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, req/ack program-memory reads, IR handoff, jump/halt handling.
// Optional illegal-opcode trap enabled by defining FETCH_ILLEGAL_TRAP_EN.
module inst_fetch #(
    parameter int                ADDR_W    = 16,
    parameter int                INST_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                LAST_OPER = 20
) (
    input  logic                clk,
    input  logic                sys_rst,
    input  logic                start,
    input  logic                halt_req,
    inst_fetch_if.master        bus,
    output logic                busy,
    output logic                illegal_op
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_HALT} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_imem_req;
    logic [INST_W-1:0] r_ir;
    logic              r_ir_valid;
    logic [ADDR_W-1:0] r_pc;
    logic              r_busy;
    logic              r_illegal_op;
    logic              w_illegal;

`ifdef FETCH_ILLEGAL_TRAP_EN
    localparam logic [4:0] LAST_OPER_C = 5'(LAST_OPER);
    assign w_illegal = (bus.imem_rdata[31:27] > LAST_OPER_C);
`else
    assign w_illegal = 1'b0;
`endif

    // imem_addr is the fetch PC itself, so it cannot drift while a request is outstanding.
    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.ir        = r_ir;
    assign bus.ir_valid  = r_ir_valid;
    assign bus.pc        = r_pc;
    assign busy          = r_busy;
    assign illegal_op    = r_illegal_op;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state      <= S_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_imem_req   <= 1'b0;
            r_ir         <= '0;
            r_ir_valid   <= 1'b0;
            r_pc         <= '0;
            r_busy       <= 1'b0;
            r_illegal_op <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_FETCH;
                        r_fetch_pc   <= RESET_PC;
                        r_imem_req   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_illegal_op <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        r_ir       <= bus.imem_rdata;
                        r_pc       <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                        r_imem_req <= 1'b0;
                        if (w_illegal) begin
                            r_illegal_op <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= S_HALT;
                        end else begin
                            r_ir_valid <= 1'b1;
                            r_state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.ir_ready) begin
                        r_ir_valid <= 1'b0;
                        if (bus.jump_en) begin
                            r_fetch_pc <= bus.jump_addr;
                        end
                        if (halt_req) begin
                            r_busy  <= 1'b0;
                            r_state <= S_HALT;
                        end else begin
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    if (start) begin
                        r_state      <= S_FETCH;
                        r_imem_req   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_illegal_op <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: bench-side memory model, PC model and IR scoreboard.
// Trap checks are compiled in when FETCH_ILLEGAL_TRAP_EN is defined.
module tb_inst_fetch;
    localparam int ADDR_W = 16;
    localparam int INST_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] ir;
    } sb_t;

    logic clk = 1'b0;
    logic sys_rst = 1'b0;
    logic start = 1'b0;
    logic halt_req = 1'b0;
    logic busy;
    logic illegal_op;

    int n_checks = 0;
    int n_errors = 0;

    logic [INST_W-1:0] mem [int];
    sb_t               sb [$];
    logic [ADDR_W-1:0] exp_pc;

    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    inst_fetch #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC('0), .LAST_OPER(20)) dut (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .halt_req   (halt_req),
        .bus        (bus),
        .busy       (busy),
        .illegal_op (illegal_op)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [INST_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return {1'b0, a[3:0], 11'h155, a};
    endfunction

    task automatic check_reset_outputs(input string p);
        check({p, "_req"},      64'(bus.imem_req),  64'(0));
        check({p, "_addr"},     64'(bus.imem_addr), 64'(0));
        check({p, "_ir"},       64'(bus.ir),        64'(0));
        check({p, "_ir_valid"}, 64'(bus.ir_valid),  64'(0));
        check({p, "_pc"},       64'(bus.pc),        64'(0));
        check({p, "_busy"},     64'(busy),          64'(0));
        check({p, "_illegal"},  64'(illegal_op),    64'(0));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 50);
        if (!ok) check("req_timeout", 64'(0), 64'(1));
    endtask

    // One fetch: memory answers after 'delay' wait cycles, execute stalls 'hold' cycles.
    task automatic fetch_one(input int delay, input int hold, input bit jmp,
                             input logic [ADDR_W-1:0] jaddr, input bit hlt, input bit stray_jump);
        bit  ok;
        sb_t e;
        wait_req(ok);
        if (!ok) return;
        check("imem_addr", 64'(bus.imem_addr), 64'(exp_pc));
        check("busy_fetch", 64'(busy), 64'(1));
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("addr_stable", 64'(bus.imem_addr), 64'(exp_pc));
            check("req_held", 64'(bus.imem_req), 64'(1));
            check("no_valid_wait", 64'(bus.ir_valid), 64'(0));
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(exp_pc);
        sb.push_back('{pc: exp_pc, ir: mem_word(exp_pc)});
        exp_pc++;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        check("ir_valid", 64'(bus.ir_valid), 64'(1));
        if (sb.size() == 0) begin
            check("sb_empty", 64'(0), 64'(1));
            return;
        end
        e = sb.pop_front();
        check("ir", 64'(bus.ir), 64'(e.ir));
        check("pc", 64'(bus.pc), 64'(e.pc));
        for (int i = 0; i < hold; i++) begin
            if (stray_jump && i == 0) begin
                bus.jump_en   = 1'b1;
                bus.jump_addr = 16'h1234;
            end
            @(negedge clk);
            bus.jump_en = 1'b0;
            check("ir_stable", 64'(bus.ir), 64'(e.ir));
            check("pc_stable", 64'(bus.pc), 64'(e.pc));
            check("no_req_hold", 64'(bus.imem_req), 64'(0));
            check("valid_hold", 64'(bus.ir_valid), 64'(1));
            check("next_addr_hold", 64'(bus.imem_addr), 64'(exp_pc));
        end
        bus.ir_ready  = 1'b1;
        bus.jump_en   = jmp;
        bus.jump_addr = jaddr;
        halt_req      = hlt;
        @(negedge clk);
        bus.ir_ready = 1'b0;
        bus.jump_en  = 1'b0;
        halt_req     = 1'b0;
        if (jmp) exp_pc = jaddr;
        check("req_after_hs", 64'(bus.imem_req), 64'(!hlt));
        check("valid_after_hs", 64'(bus.ir_valid), 64'(0));
        check("addr_after_hs", 64'(bus.imem_addr), 64'(exp_pc));
        check("busy_after_hs", 64'(busy), 64'(!hlt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        bus.ir_ready   = 1'b0;
        bus.jump_en    = 1'b0;
        bus.jump_addr  = '0;
        mem[0] = 32'h2888_0000;
        mem[1] = 32'h5088_0000;
        mem[2] = 32'h580C_0000;

        // Reset values
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        sys_rst = 1'b1;
        @(negedge clk);
        check("idle_req", 64'(bus.imem_req), 64'(0));

        // Zero-wait memory, ir_ready immediate
        exp_pc = '0;
        pulse_start();
        for (int i = 0; i < 3; i++) fetch_one(0, 0, 1'b0, '0, 1'b0, 1'b0);

        // Slow memory and stalled execute; stray jump without handshake
        fetch_one(3, 4, 1'b0, '0, 1'b0, 1'b0);
        fetch_one(1, 2, 1'b0, '0, 1'b0, 1'b1);

        // Jump at pc=5, then steer to 7 and halt there
        fetch_one(0, 0, 1'b1, 16'h0040, 1'b0, 1'b0);
        fetch_one(0, 1, 1'b1, 16'h0007, 1'b0, 1'b0);
        fetch_one(0, 0, 1'b0, '0, 1'b1, 1'b0);

        // Halted: ack while idle-requesting is ignored, state retained
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("halt_ir_kept", 64'(bus.ir), 64'(mem_word(16'h0007)));
        check("halt_pc_kept", 64'(bus.pc), 64'(7));
        check("halt_no_valid", 64'(bus.ir_valid), 64'(0));
        check("halt_no_req", 64'(bus.imem_req), 64'(0));
        check("halt_busy", 64'(busy), 64'(0));

        // Resume at 8, jump to 0xFFFF, wrap to 0x0000
        pulse_start();
        fetch_one(0, 0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        fetch_one(0, 0, 1'b0, '0, 1'b0, 1'b0);
        // Jump and halt together, then resume at the jump target
        fetch_one(0, 0, 1'b1, 16'h0100, 1'b1, 1'b0);
        pulse_start();
        fetch_one(2, 0, 1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset mid-FETCH, then a late ack
        check("pre_rst_req", 64'(bus.imem_req), 64'(1));
        #2 sys_rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        sys_rst        = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check_reset_outputs("late_ack");

        // Opcode 31 at pc=3
        mem[3] = 32'hF800_0000;
        exp_pc = '0;
        pulse_start();
        for (int i = 0; i < 3; i++) fetch_one(0, 0, 1'b0, '0, 1'b0, 1'b0);
`ifdef FETCH_ILLEGAL_TRAP_EN
        begin
            bit ok;
            wait_req(ok);
            if (ok) begin
                check("trap_addr", 64'(bus.imem_addr), 64'(3));
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_word(16'h0003);
                @(negedge clk);
                bus.imem_ack = 1'b0;
                check("trap_flag", 64'(illegal_op), 64'(1));
                check("trap_ir", 64'(bus.ir), 64'(32'hF800_0000));
                check("trap_pc", 64'(bus.pc), 64'(3));
                check("trap_busy", 64'(busy), 64'(0));
                repeat (3) begin
                    check("trap_no_valid", 64'(bus.ir_valid), 64'(0));
                    check("trap_no_req", 64'(bus.imem_req), 64'(0));
                    @(negedge clk);
                end
                check("trap_sticky", 64'(illegal_op), 64'(1));
                pulse_start();
                check("trap_cleared", 64'(illegal_op), 64'(0));
                exp_pc = 16'h0004;
                fetch_one(0, 0, 1'b0, '0, 1'b0, 1'b0);
            end
        end
`else
        fetch_one(0, 0, 1'b0, '0, 1'b0, 1'b0);
        check("no_trap_flag", 64'(illegal_op), 64'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
